// File: rtl/camo_key_cell_array_if.sv
// Key-provisioning and operand/result signals of the camouflaged cell array.
// Key beats move on key_valid & key_ready; operands are fire-and-forget, no backpressure.
interface camo_key_cell_array_if #(
  parameter int NUM_CELLS = 6
);
  logic                 key_load;
  logic                 key_bit;
  logic                 key_valid;
  logic                 key_ready;
  logic                 in_valid;
  logic [NUM_CELLS-1:0] cell_a;
  logic [NUM_CELLS-1:0] cell_b;
  logic                 out_valid;
  logic [NUM_CELLS-1:0] out_y;
  logic                 armed;
  logic                 key_fail;

  modport master (
    output key_load, key_bit, key_valid, in_valid, cell_a, cell_b,
    input  key_ready, out_valid, out_y, armed, key_fail
  );

  modport slave (
    input  key_load, key_bit, key_valid, in_valid, cell_a, cell_b,
    output key_ready, out_valid, out_y, armed, key_fail
  );
endinterface

// File: rtl/camo_key_cell_array.sv
// Keyed array of camouflaged 2-input cells; serial MSB-first key plus even-parity bit arms it.
// Operand-to-result latency 1 cycle; key_ready only in LOAD, operands are never backpressured.
module camo_key_cell_array #(
  parameter int NUM_CELLS = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  camo_key_cell_array_if.slave   bus
);
  localparam int KEY_W = 2 * NUM_CELLS;
  localparam int CNT_W = $clog2(KEY_W + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ARMED,
    S_FAIL
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [KEY_W-1:0]     r_key_sr;
  logic [KEY_W-1:0]     r_key_reg;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_par;
  logic                 r_armed;
  logic                 r_key_fail;
  logic                 r_out_valid;
  logic [NUM_CELLS-1:0] r_out_y;

  logic                 w_start;
  logic                 w_beat;
  logic                 w_par_ok;
  logic [NUM_CELLS-1:0] w_f;

  // key_load outranks a coincident key beat, which is therefore dropped
  assign w_start  = bus.key_load & (r_state != S_CHECK);
  assign w_beat   = bus.key_valid & (r_state == S_LOAD) & ~bus.key_load;
  assign w_par_ok = ~(^{r_key_sr, r_par});

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ARMED, S_FAIL: begin
        if (bus.key_load) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (bus.key_load)                            w_state_nxt = S_LOAD;
        else if (w_beat && r_cnt == CNT_W'(KEY_W))   w_state_nxt = S_CHECK;
      end
      S_CHECK: w_state_nxt = w_par_ok ? S_ARMED : S_FAIL;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_f = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      case (r_key_reg[2*i +: 2])
        2'b00:   w_f[i] = ~(bus.cell_a[i] & bus.cell_b[i]);
        2'b01:   w_f[i] = ~(bus.cell_a[i] | bus.cell_b[i]);
        2'b10:   w_f[i] = bus.cell_a[i] ^ bus.cell_b[i];
        default: w_f[i] = bus.cell_a[i] & bus.cell_b[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_key_sr   <= '0;
      r_key_reg  <= '0;
      r_cnt      <= '0;
      r_par      <= 1'b0;
      r_armed    <= 1'b0;
      r_key_fail <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_armed <= (w_state_nxt == S_ARMED);
      if (w_start) begin
        r_key_sr   <= '0;
        r_cnt      <= '0;
        r_key_fail <= 1'b0;
      end else if (w_beat) begin
        if (r_cnt < CNT_W'(KEY_W)) r_key_sr <= {r_key_sr[KEY_W-2:0], bus.key_bit};
        else                       r_par    <= bus.key_bit;
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_CHECK) begin
        if (w_par_ok) r_key_reg  <= r_key_sr;
        else          r_key_fail <= 1'b1;
      end
    end
  end

  // an operand beat in the key_load cycle still sees armed=1 and the old key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
    end else begin
      r_out_valid <= bus.in_valid & r_armed;
      if (bus.in_valid) r_out_y <= r_armed ? w_f : '0;
    end
  end

  assign bus.key_ready = (r_state == S_LOAD);
  assign bus.out_valid = r_out_valid;
  assign bus.out_y     = r_out_y;
  assign bus.armed     = r_armed;
  assign bus.key_fail  = r_key_fail;
endmodule

// File: tb/tb_camo_key_cell_array.sv
// Directed bench for camo_key_cell_array: expected results are queued at stimulus time
// and a forked monitor pops and compares them whenever out_valid is seen.
module tb_camo_key_cell_array;
  localparam int NC = 6;
  localparam logic [11:0] K1 = 12'b11_10_01_00_11_10; // 7 ones, parity 1
  localparam logic [11:0] K2 = 12'b00_01_10_11_00_01; // 5 ones, parity 1

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [NC-1:0] exp_q[$];

  camo_key_cell_array_if #(.NUM_CELLS(NC)) bus();

  camo_key_cell_array #(.NUM_CELLS(NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [NC-1:0] a, input logic [NC-1:0] b, input logic [NC-1:0] y);
    bus.in_valid = 1'b1;
    bus.cell_a   = a;
    bus.cell_b   = b;
    exp_q.push_back(y);
    tick;
    bus.in_valid = 1'b0;
  endtask

  // Loads key then parity bit; the key_load cycle also carries a key beat that must be dropped.
  task automatic load_key(input logic [11:0] k, input logic par, input bit gaps);
    logic [12:0] bits;
    bits = {k, par};
    bus.key_load  = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_bit   = 1'b1;
    tick;
    bus.key_load  = 1'b0;
    bus.key_valid = 1'b0;
    bus.in_valid  = 1'b0;
    chk("key_ready_in_load", 32'(bus.key_ready), 32'd1);
    for (int i = 12; i >= 0; i--) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.key_valid = 1'b0;
          bus.key_bit   = 1'($urandom);
          bus.in_valid  = 1'($urandom);
          bus.cell_a    = 6'($urandom);
          bus.cell_b    = 6'($urandom);
          tick;
        end
        bus.in_valid = 1'b0;
      end
      bus.key_valid = 1'b1;
      bus.key_bit   = bits[i];
      tick;
    end
    bus.key_valid = 1'b0;
    chk("armed_in_check", 32'(bus.armed), 32'd0);
    chk("key_ready_in_check", 32'(bus.key_ready), 32'd0);
    tick;
  endtask

  initial begin
    bus.key_load  = 1'b0;
    bus.key_bit   = 1'b0;
    bus.key_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.cell_a    = '0;
    bus.cell_b    = '0;

    fork
      begin
        forever begin
          @(negedge clk);
          if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_out_valid: got out_y %0h with no expected beat at %0t",
                       bus.out_y, $time);
            end else begin
              chk("out_y", 32'(bus.out_y), 32'(exp_q.pop_front()));
            end
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
      end
    join_none

    // Reset with operands active
    bus.in_valid = 1'b1;
    repeat (3) begin
      bus.cell_a = 6'($urandom);
      bus.cell_b = 6'($urandom);
      tick;
    end
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_y", 32'(bus.out_y), 32'd0);
    chk("rst_armed", 32'(bus.armed), 32'd0);
    chk("rst_key_ready", 32'(bus.key_ready), 32'd0);
    chk("rst_key_fail", 32'(bus.key_fail), 32'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    tick;

    // Good key K1
    load_key(K1, 1'b1, 1'b0);
    chk("k1_armed", 32'(bus.armed), 32'd1);
    chk("k1_key_fail", 32'(bus.key_fail), 32'd0);
    send_op(6'b111111, 6'b010101, 6'b000000);
    send_op(6'b000000, 6'b000000, 6'b001100);
    send_op(6'b101010, 6'b110011, 6'b110111);
    send_op(6'b010101, 6'b101010, 6'b010101);
    tick;
    tick;

    // Bad parity: FAIL, operand beats zero out_y with no out_valid
    load_key(K1, 1'b0, 1'b0);
    chk("bad_armed", 32'(bus.armed), 32'd0);
    chk("bad_key_fail", 32'(bus.key_fail), 32'd1);
    bus.in_valid = 1'b1;
    bus.cell_a   = 6'b111111;
    bus.cell_b   = 6'b111111;
    tick;
    bus.in_valid = 1'b0;
    tick;
    chk("bad_out_y_zero", 32'(bus.out_y), 32'd0);

    // Abort after 5 beats, then full K2
    bus.key_load = 1'b1;
    tick;
    bus.key_load = 1'b0;
    chk("restart_key_fail_clr", 32'(bus.key_fail), 32'd0);
    bus.key_valid = 1'b1;
    bus.key_bit   = 1'b1;
    repeat (5) tick;
    load_key(K2, 1'b1, 1'b0);
    chk("k2_armed", 32'(bus.armed), 32'd1);
    send_op(6'b111111, 6'b010101, 6'b101110);
    send_op(6'b000000, 6'b000000, 6'b110011);
    tick;

    // Gappy reload of K1; operand beat on the key_load cycle uses K2
    bus.in_valid = 1'b1;
    bus.cell_a   = 6'b000000;
    bus.cell_b   = 6'b000000;
    exp_q.push_back(6'b110011);
    load_key(K1, 1'b1, 1'b1);
    chk("gap_armed", 32'(bus.armed), 32'd1);
    send_op(6'b101010, 6'b110011, 6'b110111);
    tick;
    tick;

    // Async reset while armed
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_y", 32'(bus.out_y), 32'd0);
    chk("arst_armed", 32'(bus.armed), 32'd0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    tick;
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.cell_a   = 6'b111111;
    tick;
    bus.in_valid = 1'b0;
    chk("post_rst_armed", 32'(bus.armed), 32'd0);

    // Async reset mid-load discards the partial key
    bus.key_load = 1'b1;
    tick;
    bus.key_load  = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_bit   = 1'b0;
    repeat (4) tick;
    chk("midload_key_ready", 32'(bus.key_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midload_rst_key_ready", 32'(bus.key_ready), 32'd0);
    tick;
    rst_n = 1'b1;
    repeat (14) tick;
    bus.key_valid = 1'b0;
    chk("ignored_beats_armed", 32'(bus.armed), 32'd0);
    chk("ignored_beats_key_ready", 32'(bus.key_ready), 32'd0);
    load_key(K1, 1'b1, 1'b0);
    chk("reload_armed", 32'(bus.armed), 32'd1);
    send_op(6'b000000, 6'b000000, 6'b001100);
    tick;
    tick;

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
